// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer between NUM_CLIENTS byte-stream
// requesters. Round-robin arbitration with packet locking: the winner keeps the
// grant until its i_Last byte has fully left the line. Each byte is handed to the
// serializer with a one-cycle start pulse, the serializer is then expected to go
// busy (the pulse is re-issued after ACK_TIMEOUT idle cycles), and the block waits
// for it to return to idle before loading the next byte.
module uart_tx_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic [NUM_CLIENTS-1:0]   i_Valid,
    input  logic [8*NUM_CLIENTS-1:0] i_Data,
    input  logic [NUM_CLIENTS-1:0]   i_Last,
    output logic [NUM_CLIENTS-1:0]   o_Ready,
    output logic [NUM_CLIENTS-1:0]   o_Grant,
    input  logic                     i_TxIdle,
    output logic                     o_TxStart,
    output logic [7:0]               o_TxData,
    output logic                     o_Busy,
    output logic                     o_Timeout
);

    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLIENTS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ACK  = 2'd2,
        S_SEND = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       owner_next;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       rr_ptr_next;
    logic [CNT_W-1:0]       ack_cnt;
    logic [CNT_W-1:0]       ack_cnt_next;
    logic                   last_q;
    logic                   last_next;
    logic [NUM_CLIENTS-1:0] ready_next;
    logic [NUM_CLIENTS-1:0] grant_next;
    logic                   start_next;
    logic [7:0]             data_next;
    logic                   busy_next;
    logic                   timeout_next;

    logic                   owner_valid;
    logic                   owner_last;
    logic [7:0]             owner_data;

    // First requester found scanning ptr, ptr+1, ... wrapping at NUM_CLIENTS.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                                 input logic [IDX_W-1:0]       ptr);
        logic found;
        int   pos;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_CLIENTS) begin
                pos = pos - NUM_CLIENTS;
            end
            for (int k = 0; k < NUM_CLIENTS; k++) begin
                if (!found && (k == pos) && req[k]) begin
                    found   = 1'b1;
                    rr_pick = IDX_W'(k);
                end
            end
        end
    endfunction

    // Index to one-hot client vector.
    function automatic logic [NUM_CLIENTS-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        to_onehot = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (IDX_W'(k) == idx) begin
                to_onehot[k] = 1'b1;
            end
        end
    endfunction

    // Successor index modulo NUM_CLIENTS (handles non-power-of-two counts).
    function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx);
        if (idx == LAST_IDX) begin
            next_index = '0;
        end else begin
            next_index = idx + IDX_W'(1);
        end
    endfunction

    // Select the current owner's byte, valid and last flag.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (IDX_W'(k) == owner) begin
                owner_valid = i_Valid[k];
                owner_last  = i_Last[k];
                owner_data  = i_Data[8*k +: 8];
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_next   = state;
        owner_next   = owner;
        rr_ptr_next  = rr_ptr;
        ack_cnt_next = ack_cnt;
        last_next    = last_q;
        grant_next   = o_Grant;
        ready_next   = '0;
        start_next   = 1'b0;
        data_next    = o_TxData;
        timeout_next = 1'b0;

        case (state)
            S_IDLE: begin
                if (|i_Valid) begin
                    owner_next = rr_pick(i_Valid, rr_ptr);
                    grant_next = to_onehot(owner_next);
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                // A dropped i_Valid keeps the grant; other clients keep waiting.
                if (i_TxIdle && owner_valid) begin
                    start_next   = 1'b1;
                    data_next    = owner_data;
                    ready_next   = to_onehot(owner);
                    last_next    = owner_last;
                    ack_cnt_next = '0;
                    state_next   = S_ACK;
                end
            end
            S_ACK: begin
                if (!i_TxIdle) begin
                    state_next = S_SEND;
                end else if (ack_cnt == ACK_LAST) begin
                    // Serializer missed the pulse: re-issue it with the held byte.
                    timeout_next = 1'b1;
                    start_next   = 1'b1;
                    ack_cnt_next = '0;
                end else begin
                    ack_cnt_next = ack_cnt + CNT_W'(1);
                end
            end
            S_SEND: begin
                if (i_TxIdle) begin
                    if (last_q) begin
                        rr_ptr_next = next_index(owner);
                        grant_next  = '0;
                        state_next  = S_IDLE;
                    end else begin
                        state_next = S_LOAD;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    // State, bookkeeping and output registers with synchronous reset.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state     <= S_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            ack_cnt   <= '0;
            last_q    <= 1'b0;
            o_Ready   <= '0;
            o_Grant   <= '0;
            o_TxStart <= 1'b0;
            o_TxData  <= '0;
            o_Busy    <= 1'b0;
            o_Timeout <= 1'b0;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            rr_ptr    <= rr_ptr_next;
            ack_cnt   <= ack_cnt_next;
            last_q    <= last_next;
            o_Ready   <= ready_next;
            o_Grant   <= grant_next;
            o_TxStart <= start_next;
            o_TxData  <= data_next;
            o_Busy    <= busy_next;
            o_Timeout <= timeout_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed client packets, a simple serializer
// model, and a scoreboard monitor that checks each consumed byte in order.
module tb_uart_tx_arbiter;

    localparam int NC = 4;
    localparam int AT = 8;
    localparam int BIT_CYCLES = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] valid;
    logic [8*NC-1:0] data;
    logic [NC-1:0] last;
    logic [NC-1:0] ready;
    logic [NC-1:0] grant;
    logic          tx_idle;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          busy;
    logic          timeout;

    logic          cv [NC];
    logic [7:0]    cd [NC];
    logic          cl [NC];

    int            busy_cnt = 0;
    int            ignore_req = 0;
    int            ignored = 0;
    logic          force_low = 1'b0;

    int            n_checks = 0;
    int            n_fail = 0;
    int            n_timeouts = 0;
    logic [11:0]   exp_q [$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_CLIENTS(NC), .ACK_TIMEOUT(AT)) dut (
        .i_Clock  (clk),
        .i_Reset  (rst),
        .i_Valid  (valid),
        .i_Data   (data),
        .i_Last   (last),
        .o_Ready  (ready),
        .o_Grant  (grant),
        .i_TxIdle (tx_idle),
        .o_TxStart(tx_start),
        .o_TxData (tx_data),
        .o_Busy   (busy),
        .o_Timeout(timeout)
    );

    // Pack per-client stimulus into the DUT buses.
    always_comb begin
        for (int k = 0; k < NC; k++) begin
            valid[k]       = cv[k];
            data[8*k +: 8] = cd[k];
            last[k]        = cl[k];
        end
    end

    // Serializer model: busy for BIT_CYCLES after an accepted start; can ignore starts.
    always @(posedge clk) begin
        if (tx_start) begin
            if (ignore_req > ignored) ignored <= ignored + 1;
            else busy_cnt <= BIT_CYCLES;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign tx_idle = (busy_cnt == 0) && !force_low;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NC-1:0] grant_of(input logic [1:0] k);
        logic [NC-1:0] g;
        g = '0;
        g[k] = 1'b1;
        return g;
    endfunction

    task automatic push_pkt(input logic [1:0] k, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) exp_q.push_back({grant_of(k), base + 8'(i)});
    endtask

    task automatic send_pkt(input logic [1:0] k, input int n, input logic [7:0] base,
                            input int drop_cycles);
        int t;
        for (int i = 0; i < n; i++) begin
            cd[k] = base + 8'(i);
            cl[k] = (i == n - 1);
            cv[k] = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!ready[k] && t < 2000);
            if (t >= 2000) chk($sformatf("ready_wait_c%0d", k), {31'd0, ready[k]}, 1);
            if (drop_cycles > 0 && i == 0 && n > 1) begin
                cv[k] = 1'b0;
                for (int j = 0; j < drop_cycles; j++) begin
                    @(negedge clk);
                    if (j == drop_cycles / 2) begin
                        chk("hold_grant", grant, grant_of(k));
                        chk("no_ready_in_gap", ready, 0);
                    end
                end
            end
        end
        cv[k] = 1'b0;
        cl[k] = 1'b0;
    endtask

    task automatic wait_quiet();
        int t;
        t = 0;
        while ((busy || !tx_idle || exp_q.size() != 0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("settle_timeout", (t >= 1000), 0);
        @(negedge clk);
    endtask

    initial begin
        int t;
        rst = 1'b1;
        for (int k = 0; k < NC; k++) begin
            cv[k] = 1'b0;
            cd[k] = '0;
            cl[k] = 1'b0;
        end

        // Scoreboard monitor: pops one expected byte per o_Ready pulse.
        fork
            begin
                int cyc = 0;
                int last_start_cyc = 0;
                logic [7:0] last_data = '0;
                logic prev_start = 1'b0;
                logic [NC-1:0] prev_grant = '0;
                logic [11:0] e;
                forever begin
                    @(negedge clk);
                    cyc++;
                    if (!rst) begin
                        if (tx_start) begin
                            chk("start_gap", {31'd0, prev_start}, 0);
                            chk("start_source", ((ready != 0) || timeout), 1);
                        end
                        if (ready != 0) begin
                            if (exp_q.size() == 0) chk("unexpected_ready", ready, 0);
                            else begin
                                e = exp_q.pop_front();
                                chk("ready_owner", ready, e[11:8]);
                                chk("grant_owner", grant, e[11:8]);
                                chk("tx_data", tx_data, e[7:0]);
                                chk("ready_start", {31'd0, tx_start}, 1);
                            end
                        end
                        if (timeout) begin
                            n_timeouts++;
                            chk("retry_start", {31'd0, tx_start}, 1);
                            chk("retry_data", tx_data, last_data);
                            chk("retry_delay", cyc - last_start_cyc, AT);
                        end
                        if (tx_start) begin
                            last_start_cyc = cyc;
                            last_data = tx_data;
                        end
                        if (grant != prev_grant) begin
                            chk("grant_onehot0", $onehot0(grant), 1);
                            chk("busy_vs_grant", {31'd0, busy}, (grant != 0));
                            if (prev_grant != 0 && grant != 0) chk("grant_via_idle", grant, 0);
                        end
                    end
                    prev_start = tx_start;
                    prev_grant = grant;
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_grant", grant, 0);
        chk("rst_start", {31'd0, tx_start}, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_timeout", {31'd0, timeout}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Client 1 sends 0x41,0x42,0x43
        push_pkt(2'd1, 3, 8'h41);
        send_pkt(2'd1, 3, 8'h41, 0);
        wait_quiet();

        // rr_ptr is now 2: clients 0 and 3 request together, 3 wins first
        push_pkt(2'd3, 1, 8'hD3);
        push_pkt(2'd0, 1, 8'hD0);
        fork
            send_pkt(2'd0, 1, 8'hD0, 0);
            send_pkt(2'd3, 1, 8'hD3, 0);
        join
        wait_quiet();

        // From reset, all four clients with 2-byte packets: order 0,1,2,3
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NC; k++) push_pkt(2'(k), 2, 8'hA0 + 8'(16 * k));
        fork
            send_pkt(2'd0, 2, 8'hA0, 0);
            send_pkt(2'd1, 2, 8'hB0, 0);
            send_pkt(2'd2, 2, 8'hC0, 0);
            send_pkt(2'd3, 2, 8'hD0, 0);
        join
        wait_quiet();

        // Client 2 stalls 20 cycles mid-packet while client 0 is requesting
        push_pkt(2'd2, 3, 8'h60);
        push_pkt(2'd0, 1, 8'h70);
        fork
            send_pkt(2'd2, 3, 8'h60, 20);
            begin
                repeat (3) @(negedge clk);
                send_pkt(2'd0, 1, 8'h70, 0);
            end
        join
        wait_quiet();

        // Serializer ignores the first start: one retry with the same byte
        ignore_req = ignore_req + 1;
        push_pkt(2'd1, 1, 8'h55);
        send_pkt(2'd1, 1, 8'h55, 0);
        wait_quiet();

        // i_TxIdle held low at grant: start follows the rise by one cycle
        force_low = 1'b1;
        push_pkt(2'd2, 1, 8'h99);
        fork
            send_pkt(2'd2, 1, 8'h99, 0);
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    chk("no_start_while_low", {31'd0, tx_start}, 0);
                end
                chk("grant_while_low", grant, 4'b0100);
                force_low = 1'b0;
                @(negedge clk);
                chk("start_after_rise", {31'd0, tx_start}, 1);
            end
        join
        wait_quiet();

        // Reset while in S_SEND; the next start waits for the serializer
        push_pkt(2'd1, 1, 8'h33);
        send_pkt(2'd1, 1, 8'h33, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_start", {31'd0, tx_start}, 0);
        chk("mid_rst_data", tx_data, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_timeout", {31'd0, timeout}, 0);
        rst = 1'b0;
        push_pkt(2'd3, 1, 8'h44);
        fork
            send_pkt(2'd3, 1, 8'h44, 0);
            begin
                t = 0;
                while (busy_cnt != 0 && t < 50) begin
                    chk("no_start_while_busy", {31'd0, tx_start}, 0);
                    @(negedge clk);
                    t++;
                end
            end
        join
        wait_quiet();

        chk("timeout_count", n_timeouts, 1);
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx serializer between NUM_CLIENTS byte-stream requesters using round-robin arbitration with packet locking.
A grant is held from the first byte of a packet until its byte flagged i_Last has fully left the line.
The block sequences the serializer: a one-cycle start pulse, then confirmation that the serializer went busy (with timeout/retry), then wait for idle.
It sits between client logic (console, debug dump, status reporter) and a single uart_tx instance.

Parameters:
NUM_CLIENTS, 4, number of requesters (2..8).
ACK_TIMEOUT, 8, cycles to wait for i_TxIdle to fall after a start pulse before retrying.

Ports:
i_Clock  in  1  system clock.
i_Reset  in  1  synchronous active-high reset.
i_Valid  in  NUM_CLIENTS  per-client byte available.
i_Data  in  8*NUM_CLIENTS  per-client byte; client k uses bits [8k+7:8k].
i_Last  in  NUM_CLIENTS  per-client flag: the current byte ends the packet.
o_Ready  out  NUM_CLIENTS  one-cycle pulse: the granted client's byte was consumed.
o_Grant  out  NUM_CLIENTS  one-hot current owner; all zero when no owner.
i_TxIdle  in  1  serializer idle flag (uart_tx o_Idle).
o_TxStart  out  1  one-cycle start pulse to the serializer.
o_TxData  out  8  byte to the serializer; stable from the start pulse until the next load.
o_Busy  out  1  high whenever state is not S_IDLE.
o_Timeout  out  1  one-cycle pulse when an ACK timeout forces a retry.

Behaviour:
- All outputs are registered.
- Reset values: o_Ready=0, o_Grant=0, o_TxStart=0, o_TxData=0, o_Busy=0, o_Timeout=0. Also state=S_IDLE, rr_ptr=0, ack counter=0.
- S_IDLE:
  - If any i_Valid is high, grant the first asserted index scanning rr_ptr, rr_ptr+1, ... modulo NUM_CLIENTS.
  - Load o_Grant and go to S_LOAD. With no valid, stay.
- S_LOAD:
  - When i_TxIdle=1 and i_Valid[g]=1: set o_TxStart=1, o_TxData=i_Data[g], o_Ready[g]=1 (all for exactly one cycle, except o_TxData). Latch last_q=i_Last[g], clear the ack counter, go to S_ACK.
  - Otherwise hold. If the granted client drops i_Valid mid-packet, the grant is kept; other clients wait.
- S_ACK:
  - If i_TxIdle=0, go to S_SEND.
  - Else increment the counter. When the counter reaches ACK_TIMEOUT-1, pulse o_Timeout and o_TxStart (retrying the same held o_TxData), clear the counter, and stay in S_ACK.
  - Retries are unlimited. The byte is never re-requested from the client.
- S_SEND:
  - Wait for i_TxIdle=1.
  - If last_q=1: set rr_ptr=(g+1) mod NUM_CLIENTS, clear o_Grant, go to S_IDLE.
  - Else go to S_LOAD, same owner.
- Latency:
  - Valid in S_IDLE at edge n gives o_Grant at n+1.
  - If i_TxIdle is high, o_TxStart/o_Ready follow at n+2.
  - Minimum gap between bytes of one packet is 2 cycles after i_TxIdle rises.
- Client rule: a byte is consumed at the edge where o_Ready[k] is high. The client presents its next byte (or drops i_Valid) on that edge.
- Simultaneous events:
  - New requests during a packet are ignored until S_IDLE.
  - Valid for all clients at once: the owner is rr_ptr when it is valid, so each client gets exactly one packet per round.
- Single-byte packet: i_Last=1 with the first byte, and the grant releases after that byte.
- Reset mid-transfer: the controller returns to S_IDLE immediately; the serializer finishes on its own. The next S_LOAD waits for i_TxIdle=1.
- o_TxStart is never high in two consecutive cycles, and is never high while in S_IDLE or S_SEND.

Test Plan:
- Single client 1 sends 3 bytes 0x41,0x42,0x43 with Last on 0x43, serializer model idle → three o_TxStart pulses, one o_Ready[1] pulse each, o_Grant=4'b0010 throughout, then 0, rr_ptr=2.
- All 4 clients valid with 2-byte packets from reset → grant order 0,1,2,3; bytes never interleave between clients; o_Grant returns to 0 between packets.
- Client 2 drops i_Valid for 20 cycles mid-packet while client 0 is requesting → o_Grant stays 4'b0100 and no o_Ready[0]; client 0 is served only after client 2's Last byte.
- Serializer model ignores the first start (i_TxIdle stays 1) → o_Timeout and o_TxStart pulse ACK_TIMEOUT cycles later with the same o_TxData; completion then proceeds and o_Ready fires only once.
- i_TxIdle held low at grant → no o_TxStart until it rises; start is issued 1 cycle after the rise.
- Assert i_Reset during S_SEND → next cycle all outputs 0 and state S_IDLE; a new request then waits for i_TxIdle=1 before its start pulse.
